wb_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter for the single register-file write port.

---
 rtl/wb_port_arbiter.sv | 82 ++++++++
 tb/tb_wb_port_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two-requester round-robin arbiter for the register-file write port
//   clk                        single clock, all state updates on posedge
//   rst_n                      synchronous reset, active-low
//   req_a/addr_a/data_a/ack_a  main writeback requester (ack is a one-cycle pulse)
//   req_b/addr_b/data_b/ack_b  secondary writer (e.g. a multi-cycle unit)
//   sel                        last granted source (0 = A, 1 = B)
//   wr_en/wr_addr/wr_data      register-file write port
//   busy                       high during the one-cycle GRANT state
// Build option ZERO_REG_DROP_EN: grants to address 0 complete the handshake
// (ack, busy) but keep wr_en low, so writes to $0 are discarded.
module wb_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          ack_b,
  output logic          sel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state, w_state;
  logic r_last, r_sel, r_ack_a, r_ack_b, r_wr_en, r_busy;
  logic [AW-1:0] r_wr_addr, w_addr;
  logic [DW-1:0] r_wr_data, w_data;
  logic w_grant, w_pick_b, w_wr_en;
  // r_last = 1 means B won most recently, so A wins the next tie
  always_comb begin
    w_grant  = (r_state == IDLE) && (req_a || req_b);
    w_pick_b = req_b && !(req_a && r_last);
    w_state  = w_grant ? GRANT : IDLE;
    w_addr   = w_pick_b ? addr_b : addr_a;
    w_data   = w_pick_b ? data_b : data_a;
`ifdef ZERO_REG_DROP_EN
    w_wr_en  = w_grant && (w_addr != '0);
`else
    w_wr_en  = w_grant;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_sel     <= 1'b0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state;
      r_wr_en <= w_wr_en;
      r_ack_a <= w_grant && !w_pick_b;
      r_ack_b <= w_grant && w_pick_b;
      r_busy  <= w_grant;
      if (w_grant) begin
        r_sel     <= w_pick_b;
        r_last    <= w_pick_b;
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
    end
  end
  assign ack_a   = r_ack_a;
  assign ack_b   = r_ack_b;
  assign sel     = r_sel;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter against a behavioural model
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          ack_a, ack_b, sel, wr_en, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  int tests = 0;
  int fails = 0;
  wb_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
    .sel(sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Behavioural model: a write slot is either open or just used; when open,
  // any pending request wins, ties go to whoever did not win last time.
  int            m_last_winner;
  logic          m_slot_used, m_ack_a, m_ack_b, m_sel, m_wr_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  function automatic logic winner_is_b(input logic a, input logic b, input int last_winner);
    if (a && b) return last_winner == 0;
    return b;
  endfunction
  function automatic logic write_allowed(input logic [AW-1:0] a);
`ifdef ZERO_REG_DROP_EN
    return a != 0;
`else
    return 1'b1;
`endif
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      m_slot_used <= 1'b0; m_ack_a <= 1'b0; m_ack_b <= 1'b0; m_wr_en <= 1'b0;
      m_sel <= 1'b0; m_addr <= '0; m_data <= '0; m_last_winner <= 1;
    end else if (m_slot_used) begin
      m_slot_used <= 1'b0; m_ack_a <= 1'b0; m_ack_b <= 1'b0; m_wr_en <= 1'b0;
    end else if (req_a || req_b) begin
      m_slot_used   <= 1'b1;
      m_ack_a       <= !winner_is_b(req_a, req_b, m_last_winner);
      m_ack_b       <= winner_is_b(req_a, req_b, m_last_winner);
      m_sel         <= winner_is_b(req_a, req_b, m_last_winner);
      m_last_winner <= winner_is_b(req_a, req_b, m_last_winner) ? 1 : 0;
      m_addr        <= winner_is_b(req_a, req_b, m_last_winner) ? addr_b : addr_a;
      m_data        <= winner_is_b(req_a, req_b, m_last_winner) ? data_b : data_a;
      m_wr_en       <= write_allowed(winner_is_b(req_a, req_b, m_last_winner) ? addr_b : addr_a);
    end
  end
  always @(negedge clk) begin
    chk("m_ack_a", 64'(ack_a), 64'(m_ack_a));
    chk("m_ack_b", 64'(ack_b), 64'(m_ack_b));
    chk("m_busy", 64'(busy), 64'(m_slot_used));
    chk("m_sel", 64'(sel), 64'(m_sel));
    chk("m_wr_en", 64'(wr_en), 64'(m_wr_en));
    chk("m_wr_addr", 64'(wr_addr), 64'(m_addr));
    chk("m_wr_data", 64'(wr_data), 64'(m_data));
  end
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    // Reset held with req_a pending: outputs stay cleared
    req_a = 1'b1; addr_a = 5'd4; data_a = 32'h1111_2222;
    repeat (3) begin
      step();
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_ack_a", 64'(ack_a), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    rst_n = 1'b1;
    step();
    chk("rel_ack_a", 64'(ack_a), 64'd1);
    chk("rel_wr_en", 64'(wr_en), 64'd1);
    req_a = 1'b0;
    step();
    chk("rel_idle", 64'(busy), 64'd0);
    // Single A write
    req_a = 1'b1; addr_a = 5'd9; data_a = 32'hDEAD_BEEF;
    step();
    chk("a_wr_en", 64'(wr_en), 64'd1);
    chk("a_wr_addr", 64'(wr_addr), 64'd9);
    chk("a_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
    chk("a_sel", 64'(sel), 64'd0);
    chk("a_ack_a", 64'(ack_a), 64'd1);
    req_a = 1'b0;
    step();
    chk("a_after_wr_en", 64'(wr_en), 64'd0);
    chk("a_after_ack", 64'(ack_a), 64'd0);
    chk("a_after_addr_hold", 64'(wr_addr), 64'd9);
    // Tie after reset: A, B, A, B every other cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1;
    addr_a = 5'd3; data_a = 32'hAAAA_0003; addr_b = 5'd7; data_b = 32'hBBBB_0007;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("tie_ack_a", 64'(ack_a), 64'((k % 4) == 0));
      chk("tie_ack_b", 64'(ack_b), 64'((k % 4) == 2));
      chk("tie_sel", 64'(sel), 64'((k / 2) % 2));
    end
    req_a = 1'b0; req_b = 1'b0;
    step();
    // Late arrival of B during A's grant
    req_a = 1'b1; addr_a = 5'd1; data_a = 32'h0000_00A1;
    step();
    chk("late_ack_a", 64'(ack_a), 64'd1);
    req_a = 1'b0; req_b = 1'b1; addr_b = 5'd2; data_b = 32'h0000_00B2;
    step();
    chk("late_gap_ack_b", 64'(ack_b), 64'd0);
    chk("late_gap_ack_a", 64'(ack_a), 64'd0);
    step();
    chk("late_ack_b", 64'(ack_b), 64'd1);
    chk("late_addr_b", 64'(wr_addr), 64'd2);
    req_b = 1'b0;
    step();
    chk("late_idle", 64'(wr_en), 64'd0);
    // Reset during B's grant, B re-granted afterwards
    req_b = 1'b1; addr_b = 5'd12; data_b = 32'hC0FF_EE12;
    step();
    chk("mid_ack_b", 64'(ack_b), 64'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_ack_b", 64'(ack_b), 64'd0);
    rst_n = 1'b1;
    step();
    chk("regrant_ack_b", 64'(ack_b), 64'd1);
    chk("regrant_wr_en", 64'(wr_en), 64'd1);
    chk("regrant_addr", 64'(wr_addr), 64'd12);
    req_b = 1'b0;
    step();
    // Grant to address 0
    req_a = 1'b1; addr_a = 5'd0; data_a = 32'h5555_0000;
    step();
    chk("zero_ack_a", 64'(ack_a), 64'd1);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_addr", 64'(wr_addr), 64'd0);
`ifdef ZERO_REG_DROP_EN
    chk("zero_wr_en", 64'(wr_en), 64'd0);
`else
    chk("zero_wr_en", 64'(wr_en), 64'd1);
`endif
    req_a = 1'b0;
    step();
    // Randomized requesters obeying the handshake rules, occasional resets
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n = ($urandom_range(0, 99) != 0);
      if (!req_a || ack_a) begin
        req_a  = ($urandom_range(0, 2) != 0);
        addr_a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        data_a = $urandom;
      end
      if (!req_b || ack_b) begin
        req_b  = ($urandom_range(0, 2) != 0);
        addr_b = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        data_b = $urandom;
      end
    end
    rst_n = 1'b1; req_a = 1'b0; req_b = 1'b0;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
